priority_arbiter_n: RTL and testbench

//   Parametrised, registered N-input priority encoder with grant handshake.

---
 rtl/priority_arbiter_n.sv | 108 ++++++++++
 tb/tb_priority_arbiter_n.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n: registered N-input priority arbiter with grant handshake.
// Samples W when en is high and no grant is held (or the held grant is being
// released with done). The winning index is registered into Y with z/busy
// marking a live grant. The grant is held until done.
// Build option: define ROUND_ROBIN_EN to get rotating priority. The search
// starts at ptr and descends with wrap. Otherwise fixed MSB-first priority.
module priority_arbiter_n #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  W,
  input  logic          en,
  input  logic          done,
  output logic [IW-1:0] Y,
  output logic          z,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] win;
  logic          take, load, clr;

  assign take = en && (|W);

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  // Rotating search: offset 0 (ptr itself) is checked last so it wins,
  // then ptr-1, ... wrapping below 0 back to N-1.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    win = '0;
    idx = 0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) - k;
      if (idx < 0) idx = idx + N;
      sel = IW'(idx);
      if (W[sel]) win = sel;
    end
  end

  // Pointer moves just below the index granted, so that index is served last next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= IW'(N - 1);
    else if (load) ptr <= (win == '0) ? IW'(N - 1) : win - IW'(1);
  end
`else
  // Fixed priority: scan upward so the highest set bit is the last assignment.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (W[i]) win = IW'(i);
    end
  end
`endif

  // Next state plus Y load/clear strobes; W and en only matter when not holding.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = GRANT;
          load      = 1'b1;
        end
      end
      GRANT: begin
        if (done) begin
          if (take) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            clr       = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Granted index. It is zeroed on release, so Y is 0 whenever z is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    Y <= '0;
    else if (load) Y <= win;
    else if (clr)  Y <= '0;
  end

  assign z    = (state == GRANT);
  assign busy = z;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Scoreboard bench for priority_arbiter_n (N=4). A reference model pushes the
// expected {z,Y} after every clock edge; a monitor pops and compares.
module tb_priority_arbiter_n;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  W     = '0;
  logic          en    = 1'b0;
  logic          done  = 1'b0;
  logic [IW-1:0] Y;
  logic          z;
  logic          busy;

  priority_arbiter_n #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .W    (W),
    .en   (en),
    .done (done),
    .Y    (Y),
    .z    (z),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic        probe  = 1'b0;
  logic [IW:0] q[$];

  // Reference model: whether a grant is held, and which index.
  int m_g  = 0;
  int m_gi = 0;
`ifdef ROUND_ROBIN_EN
  int m_ptr = N - 1;
`endif

  function automatic int winner(logic [N-1:0] w);
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      if (w[(m_ptr - k + N) % N]) return (m_ptr - k + N) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (w[i]) return i;
    end
`endif
    return 0;
  endfunction

  // Model: evaluated at each active edge with the inputs as the DUT sees them.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_g  = 0;
      m_gi = 0;
`ifdef ROUND_ROBIN_EN
      m_ptr = N - 1;
`endif
    end else begin
      if (m_g == 0 || done) begin
        if (en && W != '0) begin
          m_gi = winner(W);
          m_g  = 1;
`ifdef ROUND_ROBIN_EN
          m_ptr = (m_gi == 0) ? N - 1 : m_gi - 1;
`endif
        end else begin
          m_g  = 0;
          m_gi = 0;
        end
      end
      q.push_back({m_g[0], m_gi[IW-1:0]});
    end
  end

  task automatic check(input string name, input logic [IW+1:0] act, input logic [IW+1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got busy/z/Y=%0b/%0b/%0d want %0b/%0b/%0d",
                  name, $time, act[IW+1], act[IW], act[IW-1:0], exp[IW+1], exp[IW], exp[IW-1:0]);
  endtask

  // Monitor: compares 1 unit after each edge, plus a mid-cycle async-reset probe.
  initial forever begin
    logic        r;
    logic [IW:0] e;
    @(posedge clk);
    r = rst_n;
    #1;
    if (!r) begin
      check("reset", {busy, z, Y}, '0);
    end else if (q.size() == 0) begin
      total++;
      $display("FAIL scoreboard_empty @%0t: got no expected entry, want one", $time);
    end else begin
      e = q.pop_front();
      check("grant", {busy, z, Y}, {e[IW], e});
    end
    #3;
    if (probe) check("async_rst", {busy, z, Y}, '0);
  end

  task automatic drive(input logic [N-1:0] w, input logic e, input logic d);
    @(negedge clk);
    W = w; en = e; done = d;
  endtask

  initial begin
    // Reset held with active requests: no grant may appear.
    W = 4'b1111; en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; W = '0; en = 1'b0;

    drive(4'b0110, 1'b1, 1'b0);                  // grant 2
    repeat (3) drive(4'b1000, 1'b1, 1'b0);       // held despite W change
    drive(4'b0000, 1'b0, 1'b1);                  // release -> idle
    repeat (2) drive(4'b0000, 1'b1, 1'b0);       // W=0: no grant
    drive(4'b0110, 1'b1, 1'b0);                  // grant 2
    drive(4'b1001, 1'b1, 1'b1);                  // back-to-back re-arbitration
    drive(4'b0000, 1'b0, 1'b1);                  // release
    repeat (6) drive(4'b1111, 1'b1, 1'b1);       // all requesting, done each cycle
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);                  // done in idle is ignored

    // Async reset in the middle of a grant on index 3.
    drive(4'b1000, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0; probe = 1'b1;
    @(negedge clk);
    probe = 1'b0; W = 4'b0011; en = 1'b1; done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0011, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);

    // Random traffic.
    repeat (400) drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));

    repeat (3) drive('0, 1'b0, 1'b1);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
